// File: rtl/alu_rr_scheduler_pkg.sv
// Shared opcode and FSM state definitions for the round-robin ALU scheduler.
package alu_rr_scheduler_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module alu_rr_scheduler_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU among NUM_REQ requesters, round-robin,
// returning each tagged result on a valid/ready response channel.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_op,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [1:0]            alu_op,
  input  logic [DATA_W:0]       alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W:0]       rsp_result,
  output logic                  busy
);

  state_e          state, state_nxt;
  logic [ID_W-1:0] ptr, win_id;
  logic [NUM_REQ-1:0] pick_req, pick_gnt;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            accept, rsp_fire;

  assign pick_req  = (state == ST_IDLE) ? req_valid : '0;
  assign req_ready = pick_gnt;
  assign accept    = (state == ST_IDLE) && pick_any;
  assign rsp_fire  = (state == ST_RESP) && rsp_valid && rsp_ready;
  assign busy      = (state != ST_IDLE);

  alu_rr_scheduler_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = ST_EXEC;
      ST_EXEC:               state_nxt = ST_RESP;
      ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // alu_* keep their last operands after EXEC; only accept reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      win_id     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        alu_a  <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
        alu_b  <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
        alu_op <= req_op[int'(pick_idx)*2 +: 2];
        win_id <= pick_idx;
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_id     <= win_id;
        rsp_valid  <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        ptr       <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench: table-driven single ops plus arbitration/backpressure/reset sequences.
module tb_alu_rr_scheduler;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*2-1:0]  req_op;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    alu_a, alu_b;
  logic [1:0]       alu_op;
  logic [DW:0]      alu_result;
  logic             rsp_valid, rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [DW:0]      rsp_result;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int res;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    op;
    int            res;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  // Stand-in for the external shared ALU.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_result = {1'b0, alu_a & alu_b};
      default: alu_result = {1'b0, alu_a | alu_b};
    endcase
  end

  alu_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response handshake must match the oldest grant.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d result 0x%0h expected no response", rsp_id, rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", int'(rsp_id), e.id);
        chk("rsp_result", int'(rsp_result), e.res);
      end
    end
  end

  task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    req_valid[id]       = 1'b1;
    req_a[id*DW +: DW]  = a;
    req_b[id*DW +: DW]  = b;
    req_op[id*2 +: 2]   = op;
  endtask

  // Wait (bounded) for a grant, check it is exp_id, push expectation, step past accept edge.
  task automatic grant_expect(input int exp_id, input int exp_res, input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) chk("grant_timeout", 0, 1);
    chk("req_ready_grant", int'(req_ready), 1 << exp_id);
    sb.push_back('{id: exp_id, res: exp_res});
    @(posedge clk);
    #1;
    if (drop) req_valid[exp_id] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{id: 0, a: 4'h3, b: 4'h5, op: 2'b00, res: 'h08};
    vecs[1] = '{id: 2, a: 4'hF, b: 4'h1, op: 2'b00, res: 'h10};
    vecs[2] = '{id: 2, a: 4'h3, b: 4'h7, op: 2'b01, res: 'h1C};
    vecs[3] = '{id: 2, a: 4'hA, b: 4'h5, op: 2'b10, res: 'h00};
    vecs[4] = '{id: 3, a: 4'h9, b: 4'h9, op: 2'b01, res: 'h00};
    vecs[5] = '{id: 1, a: 4'h0, b: 4'h1, op: 2'b01, res: 'h1F};

    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);

    // Single-requester vectors with exact cycle-by-cycle latency.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      @(negedge clk);
      chk("T_req_ready", int'(req_ready), 1 << vecs[i].id);
      chk("T_busy", int'(busy), 0);
      sb.push_back('{id: vecs[i].id, res: vecs[i].res});
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("T1_alu_a", int'(alu_a), int'(vecs[i].a));
      chk("T1_alu_b", int'(alu_b), int'(vecs[i].b));
      chk("T1_alu_op", int'(alu_op), int'(vecs[i].op));
      chk("T1_busy", int'(busy), 1);
      chk("T1_rsp_valid", int'(rsp_valid), 0);
      @(negedge clk);
      chk("T2_rsp_valid", int'(rsp_valid), 1);
      @(negedge clk);
      chk("T3_busy", int'(busy), 0);
      chk("T3_rsp_valid", int'(rsp_valid), 0);
    end

    // All four held valid from reset: 0,1,2,3,0.
    do_reset();
    #1;
    set_req(0, 4'hC, 4'h3, 2'b11);
    set_req(1, 4'h1, 4'h2, 2'b11);
    set_req(2, 4'h8, 4'h0, 2'b11);
    set_req(3, 4'h5, 4'hA, 2'b11);
    grant_expect(0, 'h0F, 1'b0);
    grant_expect(1, 'h03, 1'b0);
    grant_expect(2, 'h08, 1'b0);
    grant_expect(3, 'h0F, 1'b0);
    grant_expect(0, 'h0F, 1'b0);
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Backpressure: hold response 5 cycles while another request waits.
    #1 rsp_ready = 1'b0;
    set_req(1, 4'h2, 4'h3, 2'b00);
    grant_expect(1, 'h05, 1'b1);
    set_req(0, 4'h1, 4'h1, 2'b00);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_id", int'(rsp_id), 1);
      chk("bp_rsp_result", int'(rsp_result), 'h05);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_busy", int'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("bp_still_busy", int'(busy), 1);
    @(negedge clk);
    chk("bp_idle_after", int'(busy), 0);

    // Pointer: after grant to 2, req3 beats req0.
    @(posedge clk);
    #1 set_req(2, 4'h4, 4'h4, 2'b00);
    grant_expect(2, 'h08, 1'b1);
    set_req(0, 4'h6, 4'h3, 2'b10);
    set_req(3, 4'h7, 4'h1, 2'b00);
    grant_expect(3, 'h08, 1'b1);
    grant_expect(0, 'h02, 1'b1);
    repeat (4) @(posedge clk);

    // Reset during EXEC discards the transaction.
    #1 set_req(0, 4'h7, 4'h6, 2'b11);
    @(negedge clk);
    chk("rst_mid_grant", int'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_exec_busy", int'(busy), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rsp_valid", int'(rsp_valid), 0);
    chk("rst_mid_alu_a", int'(alu_a), 0);
    chk("rst_mid_alu_op", int'(alu_op), 0);
    chk("rst_mid_rsp_result", int'(rsp_result), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_rsp", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    set_req(1, 4'h2, 4'h2, 2'b00);
    set_req(3, 4'hF, 4'hF, 2'b00);
    grant_expect(1, 'h04, 1'b1);
    grant_expect(3, 'h1E, 1'b1);
    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one combinational 4-bit ALU among NUM_REQ requesters.
- Arbitrates among pending requests and registers the winner's operands onto the ALU input ports.
- Captures the ALU result and returns it on a tagged response channel with valid/ready backpressure.
- Sits between the requester bus and the shared ALU datapath; the ALU itself stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand width; result width is DATA_W+1
ID_W, $clog2(NUM_REQ), requester index width (localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_a  input  NUM_REQ*DATA_W  packed operand A; requester i uses slice [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  packed operand B, same packing
req_op  input  NUM_REQ*2  packed opcodes: 00 ADD, 01 SUB, 10 AND, 11 OR
req_ready  output  NUM_REQ  one-hot accept strobe; a request is taken when req_valid[i] & req_ready[i]
alu_a  output  DATA_W  registered operand to shared ALU
alu_b  output  DATA_W  registered operand to shared ALU
alu_op  output  2  registered opcode to shared ALU
alu_result  input  DATA_W+1  combinational ALU result
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of the requester that owns the response
rsp_result  output  DATA_W+1  captured ALU result
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: state IDLE, prio pointer 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_id 0, rsp_result 0, busy 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: the one-hot round-robin winner among req_valid, searching from the prio pointer upward with modulo-NUM_REQ wrap.
  - req_ready is all-zero when req_valid is 0 and in every other state.
  - On accept: register the winner's a/b/op into alu_*, register the winner's index, go to EXEC.
- EXEC: one cycle for the ALU to settle. Capture alu_result into rsp_result, load rsp_id, set rsp_valid, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_result stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid, set the prio pointer to winner+1 (wrap NUM_REQ-1 -> 0), go to IDLE.
- Latency: accept at cycle T gives rsp_valid at T+2. With rsp_ready held high, one op completes every 3 cycles.
- alu_* hold their last operands outside EXEC; no re-zeroing.
- Result width is DATA_W+1. The block never modifies the ALU result (SUB borrow appears in bit DATA_W).
- A requester may drop req_valid before it is granted; no stickiness is required. Fairness holds only for requests that stay asserted.
- Any requester held valid is granted within NUM_REQ grants.
- A pending request's operands may change freely until it is accepted; only the accept-cycle values are used.
- rst asserted in EXEC or RESP: the transaction is discarded, no response is emitted, and the pointer returns to 0.
- rsp_ready high while rsp_valid is low: ignored.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP.
- Sub-module rr_pick is natural: purely combinational. Inputs: req vector and pointer. Outputs: one-hot grant, grant index, any flag. It is reusable by other shared-resource arbiters.
- The top level holds the FSM, operand/result registers and the pointer.

Test Plan:
1. Single request: req0 a=3, b=5, op=00, rsp_ready=1. Expect req_ready=0001 at T, alu_a=3/alu_b=5 at T+1, rsp_valid with rsp_id=0 and rsp_result=0x08 at T+2, busy low at T+3.
2. Wrap and borrow: req2 op=00 a=F b=1 gives 0x10. Then op=01 a=3 b=7 gives 0x1C. Then req2 op=10 a=A b=5 gives 0x00.
3. All four requesters held valid from reset: grants occur in order 0,1,2,3,0. Each response's rsp_id matches, and rsp_result equals each requester's a|b for op=11 (C|3=0x0F).
4. Backpressure: rsp_ready low for 5 cycles in RESP. Expect rsp_valid, rsp_id and rsp_result stable, req_ready=0000 and busy=1. On release, IDLE is re-entered one cycle later.
5. Pointer: after a grant to 2, with req0 and req3 valid, req3 wins next, then req0.
6. Reset mid-op: assert rst during EXEC. Expect no rsp_valid ever for that op, all outputs at reset values next cycle, and a subsequent req1 and req3 contest granted to 1 first.
